// File: rtl/fir_ctrl_pkg.sv
// Shared types and constants for the 3-tap FIR frame controller.
// Optional overflow check is enabled by defining FIR_OVF_CHECK_EN.
package fir_ctrl_pkg;

    localparam int COEF_W   = 8;
    localparam int SAMPLE_W = 8;
    localparam int ACC_W    = 16;

    localparam logic [1:0] CFG_ADDR_C0     = 2'd0;
    localparam logic [1:0] CFG_ADDR_C1     = 2'd1;
    localparam logic [1:0] CFG_ADDR_C2     = 2'd2;
    localparam logic [1:0] CFG_ADDR_COMMIT = 2'd3;

    // 255 * sum exceeds 16 bits once the coefficient sum passes this value
    localparam logic [COEF_W+1:0] OVF_SUM_LIMIT = 10'd257;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        SWAP  = 2'd3
    } state_t;

    typedef struct packed {
        logic [COEF_W-1:0] c0;
        logic [COEF_W-1:0] c1;
        logic [COEF_W-1:0] c2;
    } coef_bank_t;

    function automatic logic [COEF_W+1:0] coef_sum(input coef_bank_t b);
        return {2'b00, b.c0} + {2'b00, b.c1} + {2'b00, b.c2};
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient store: shadow writes, commit request, swap to active.
// FIR_OVF_CHECK_EN adds a registered coefficient-sum overflow flag captured at swap.
module fir_coef_bank
    import fir_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    input  logic [1:0]        cfg_addr,
    input  logic [COEF_W-1:0] cfg_data,
    input  logic              swap,
    output coef_bank_t        active,
    output logic              commit_wr,
    output logic              commit_pend
`ifdef FIR_OVF_CHECK_EN
    ,
    output logic              cfg_ovf
`endif
);

    logic [2:0][COEF_W-1:0] active_lanes;
`ifdef FIR_OVF_CHECK_EN
    logic [2:0][COEF_W-1:0] shadow_lanes;
    coef_bank_t             shadow;
    logic                   ovf_reg;
`endif
    logic                   commit_pend_reg;

    assign commit_wr = cfg_valid && (cfg_addr == CFG_ADDR_COMMIT);

    // Lane index doubles as the coefficient write address (c0..c2 = 0..2)
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            logic [COEF_W-1:0] shadow_reg;
            logic [COEF_W-1:0] active_reg;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    shadow_reg <= '0;
                    active_reg <= '0;
                end else begin
                    if (swap)
                        active_reg <= shadow_reg;
                    if (cfg_valid && (cfg_addr == 2'(gi)))
                        shadow_reg <= cfg_data;
                end
            end

            assign active_lanes[gi] = active_reg;
`ifdef FIR_OVF_CHECK_EN
            assign shadow_lanes[gi] = shadow_reg;
`endif
        end
    endgenerate

    assign active = '{c0: active_lanes[0], c1: active_lanes[1], c2: active_lanes[2]};

    always_ff @(posedge clk) begin
        if (!reset)
            commit_pend_reg <= 1'b0;
        else if (commit_wr)
            commit_pend_reg <= 1'b1;
        else if (swap)
            commit_pend_reg <= 1'b0;
    end

    assign commit_pend = commit_pend_reg;

`ifdef FIR_OVF_CHECK_EN
    assign shadow = '{c0: shadow_lanes[0], c1: shadow_lanes[1], c2: shadow_lanes[2]};

    // Shadow is what becomes active on this edge, so it is the set being judged
    always_ff @(posedge clk) begin
        if (!reset)
            ovf_reg <= 1'b0;
        else if (swap)
            ovf_reg <= (coef_sum(shadow) > OVF_SUM_LIMIT);
    end

    assign cfg_ovf = ovf_reg;
`endif

endmodule

// File: rtl/fir_frame_ctrl.sv
// Frame sequencer for a 3-tap transposed FIR: feeds samples, drains the tail, swaps coefficients between frames.
// Defining FIR_OVF_CHECK_EN exposes cfg_ovf from the coefficient bank.
module fir_frame_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int FRAME_W   = 16,
    parameter int FLUSH_LEN = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_data,
    input  logic                s_last,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [1:0]          cfg_addr,
    input  logic [COEF_W-1:0]   cfg_data,
    output logic [SAMPLE_W-1:0] fir_din,
    output logic [COEF_W-1:0]   fir_c0,
    output logic [COEF_W-1:0]   fir_c1,
    output logic [COEF_W-1:0]   fir_c2,
    output logic                fir_rst,
    input  logic [ACC_W-1:0]    fir_dout,
    output logic                m_valid,
    output logic [ACC_W-1:0]    m_data,
    output logic                m_last,
    output logic                busy,
    output logic                commit_pend,
    output logic                err_gap,
    output logic [FRAME_W-1:0]  frame_len
`ifdef FIR_OVF_CHECK_EN
    ,
    output logic                cfg_ovf
`endif
);

    localparam int                 FL_W    = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
    localparam logic [FRAME_W-1:0] MAX_LEN = '1;

    state_t                state_reg, state_next;
    logic [SAMPLE_W-1:0]   din_reg, din_next;
    logic [FRAME_W-1:0]    cnt_reg, cnt_next;
    logic [FRAME_W-1:0]    cnt_base, cnt_inc;
    logic [FL_W-1:0]       flush_reg, flush_next;
    logic                  m_valid_reg, m_valid_next;
    logic                  m_last_reg, m_last_next;
    logic                  err_gap_reg, err_gap_next;
    logic [FRAME_W-1:0]    frame_len_reg, frame_len_next;
    logic                  ready_c;
    logic                  swap;
    logic                  take_last;
    logic                  hit_max;
    logic                  commit_wr;
    coef_bank_t            active;

    fir_coef_bank u_bank (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .swap       (swap),
        .active     (active),
        .commit_wr  (commit_wr),
        .commit_pend(commit_pend)
`ifdef FIR_OVF_CHECK_EN
        ,
        .cfg_ovf    (cfg_ovf)
`endif
    );

    always_comb begin
        state_next     = state_reg;
        din_next       = '0;
        cnt_next       = cnt_reg;
        flush_next     = flush_reg;
        m_valid_next   = 1'b0;
        m_last_next    = 1'b0;
        err_gap_next   = err_gap_reg;
        frame_len_next = frame_len_reg;
        ready_c        = 1'b0;
        swap           = 1'b0;
        // The first sample of a frame is taken in IDLE, so counting restarts there
        cnt_base       = (state_reg == IDLE) ? '0 : cnt_reg;
        cnt_inc        = cnt_base + FRAME_W'(1);
        take_last      = s_valid && s_last;
        hit_max        = (cnt_inc == MAX_LEN);

        case (state_reg)
            IDLE, RUN: begin
                ready_c = 1'b1;
                if ((state_reg == RUN) || s_valid) begin
                    // Every slot inside a frame produces a beat; a gap becomes a zero sample
                    din_next     = s_valid ? s_data : '0;
                    m_valid_next = 1'b1;
                    cnt_next     = cnt_inc;
                    if (!s_valid)
                        err_gap_next = 1'b1;
                    if (take_last || hit_max) begin
                        state_next     = FLUSH;
                        flush_next     = '0;
                        frame_len_next = cnt_inc;
                        if (!take_last)
                            err_gap_next = 1'b1;
                    end else begin
                        state_next = RUN;
                    end
                end else if (commit_pend || commit_wr) begin
                    state_next = SWAP;
                end
            end
            FLUSH: begin
                m_valid_next = 1'b1;
                if (flush_reg == FL_W'(FLUSH_LEN - 1)) begin
                    m_last_next = 1'b1;
                    state_next  = (commit_pend || commit_wr) ? SWAP : IDLE;
                end else begin
                    flush_next = flush_reg + FL_W'(1);
                end
            end
            SWAP: begin
                swap       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            din_reg       <= '0;
            cnt_reg       <= '0;
            flush_reg     <= '0;
            m_valid_reg   <= 1'b0;
            m_last_reg    <= 1'b0;
            err_gap_reg   <= 1'b0;
            frame_len_reg <= '0;
        end else begin
            state_reg     <= state_next;
            din_reg       <= din_next;
            cnt_reg       <= cnt_next;
            flush_reg     <= flush_next;
            m_valid_reg   <= m_valid_next;
            m_last_reg    <= m_last_next;
            err_gap_reg   <= err_gap_next;
            frame_len_reg <= frame_len_next;
        end
    end

    assign s_ready   = ready_c && reset;
    assign cfg_ready = reset;
    assign fir_din   = din_reg;
    assign fir_c0    = active.c0;
    assign fir_c1    = active.c1;
    assign fir_c2    = active.c2;
    assign fir_rst   = ~reset;
    assign m_valid   = m_valid_reg;
    assign m_data    = fir_dout;
    assign m_last    = m_last_reg;
    assign busy      = (state_reg != IDLE);
    assign err_gap   = err_gap_reg;
    assign frame_len = frame_len_reg;

endmodule
